// File: rtl/mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction-fetch stage that sits in front of the main control unit of the
// single-cycle MIPS core. It owns the PC and fetches one instruction at a time
// from instruction memory over a req/ready handshake. It holds that instruction,
// with opcode/func split out, while the datapath executes it. When the datapath
// signals exec_done, it computes the next PC from the Branch/Zero/Jump results.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   imem_req        : fetch request, high in FETCH only
//   imem_addr       : byte address being fetched (always equal to pc)
//   imem_rdata      : instruction word, captured when imem_ready=1 in FETCH
//   imem_ready      : memory response strobe
//   exec_done       : datapath finished the held instruction this cycle
//   branch/zero/jump: control-unit/ALU results used for next-PC selection
//   instr_valid     : instr/opcode/func/pc describe an executing instruction
//   instr, opcode, func : held instruction word and its control fields
//   pc, pc_plus4    : address of held instruction and its sequential successor
//   instr_count     : number of retired instructions (wraps)
//   fetch_err       : sticky flag, memory failed to answer within TIMEOUT cycles
// -----------------------------------------------------------------------------
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        fetch_err
);

  // The wait counter only needs to reach TIMEOUT-1; the error is taken on the
  // edge where it already sits there and memory is still not ready.
  localparam int unsigned     WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       count_q, count_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [31:0] seq_pc;
  logic [31:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;

  // ---------------------------------------------------------------------------
  // Next-PC computation. pc is always word aligned, so every target keeps the
  // two low bits at zero by construction.
  // ---------------------------------------------------------------------------
  always_comb begin
    seq_pc     = pc_q + 32'd4;
    branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branch_tgt = seq_pc + branch_off;
    jump_tgt   = {seq_pc[31:28], instr_q[25:0], 2'b00};

    // Jump wins over branch. An unknown jump/branch (control unit decoding an
    // undefined opcode) fails the if-test and falls through to sequential flow.
    if (jump) begin
      next_pc = jump_tgt;
    end else if (branch && zero) begin
      next_pc = branch_tgt;
    end else begin
      next_pc = seq_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    wait_d  = wait_q;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          wait_d  = '0;
          valid_d = 1'b1;
          state_d = ST_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_ERROR: begin
        // Terminal until reset; every input is ignored here.
        valid_d = 1'b0;
        err_d   = 1'b1;
      end

      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign func        = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign instr_count = count_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for mips_fetch_unit.
// Two instances share all stimulus: one resets to 0x0000_0000 and one resets to
// 0x8000_0040, so the jump region test and the low-address tests run together.
// The driver plays instruction memory and the datapath. It pushes each expected
// instruction (pc for both instances, word, retired count) into a scoreboard.
// A negedge monitor pops an entry when instr_valid rises and compares it.
// -----------------------------------------------------------------------------
module tb_mips_fetch_unit;

  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] RESET_LO = 32'h0000_0000;
  localparam logic [31:0] RESET_HI = 32'h8000_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;

  logic        req      [2];
  logic [31:0] addr     [2];
  logic        valid    [2];
  logic [31:0] instr    [2];
  logic [5:0]  opcode   [2];
  logic [5:0]  func     [2];
  logic [31:0] pc       [2];
  logic [31:0] pc_plus4 [2];
  logic [31:0] count    [2];
  logic        err      [2];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      mips_fetch_unit #(
        .RESET_PC ((gi == 0) ? RESET_LO : RESET_HI),
        .TIMEOUT  (TIMEOUT)
      ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req[gi]),
        .imem_addr   (addr[gi]),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .exec_done   (exec_done),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .instr_valid (valid[gi]),
        .instr       (instr[gi]),
        .opcode      (opcode[gi]),
        .func        (func[gi]),
        .pc          (pc[gi]),
        .pc_plus4    (pc_plus4[gi]),
        .instr_count (count[gi]),
        .fetch_err   (err[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scoreboard, reference state, check bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] word;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc [2];
  logic [31:0] m_count;
  int          checks = 0;
  int          errors = 0;
  int          txn = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Architectural next-PC rule, written with plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic b, input logic z, input logic j);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
    if (b && z) begin
      off = int'(w & 32'h0000_FFFF);
      if (off >= 32768) off = off - 65536;
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops one expected instruction per rising instr_valid and checks
  // that the held instruction stays put while it executes.
  // ---------------------------------------------------------------------------
  logic prev_valid = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (valid[0] && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_instr", 32'd1, 32'd0);
      end else begin
        cur = sb_q.pop_front();
        txn++;
        $display("txn %0d: pc=%h/%h instr=%h count=%0d", txn, pc[0], pc[1], instr[0], count[0]);
        for (int k = 0; k < 2; k++) begin
          chk("txn_pc", pc[k], (k == 0) ? cur.pc0 : cur.pc1);
          chk("txn_pc_plus4", pc_plus4[k], ((k == 0) ? cur.pc0 : cur.pc1) + 32'd4);
          chk("txn_instr", instr[k], cur.word);
          chk("txn_opcode", 32'(opcode[k]), cur.word >> 26);
          chk("txn_func", 32'(func[k]), cur.word % 64);
          chk("txn_count", count[k], cur.cnt);
          chk("txn_valid_hi", 32'(valid[k]), 32'd1);
        end
      end
    end else if (valid[0] && prev_valid) begin
      chk("hold_instr", instr[0], cur.word);
      chk("hold_pc", pc[0], cur.pc0);
    end
    prev_valid = valid[0];
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    exec_done = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    jump = 1'b0;
    #1;
    chk("rst_sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    m_pc[0] = RESET_LO;
    m_pc[1] = RESET_HI;
    m_count = '0;
    // Reset is asynchronous: values must already be back without a clock edge.
    for (int k = 0; k < 2; k++) begin
      chk("rst_pc", pc[k], m_pc[k]);
      chk("rst_pc_plus4", pc_plus4[k], m_pc[k] + 32'd4);
      chk("rst_instr", instr[k], 32'd0);
      chk("rst_opcode", 32'(opcode[k]), 32'd0);
      chk("rst_func", 32'(func[k]), 32'd0);
      chk("rst_valid", 32'(valid[k]), 32'd0);
      chk("rst_req", 32'(req[k]), 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
      chk("rst_count", count[k], 32'd0);
    end
    step();
    step();
    rst_n = 1'b1;
    chk("rst_release_req", 32'(req[0]), 32'd0);
    step();
  endtask

  // One full instruction: FETCH with w wait states, EXEC for d idle cycles,
  // then exec_done with the given branch/zero/jump.
  task automatic run_instr(input logic [31:0] word, input int w, input int d,
                           input logic b, input logic z, input logic j);
    sb_q.push_back('{m_pc[0], m_pc[1], word, m_count});
    for (int i = 0; i <= w; i++) begin
      chk("fetch_req", 32'(req[0]), 32'd1);
      chk("fetch_addr", addr[0], m_pc[0]);
      chk("fetch_addr_hi", addr[1], m_pc[1]);
      chk("fetch_valid", 32'(valid[0]), 32'd0);
      chk("fetch_err", 32'(err[0]), 32'd0);
      imem_ready = (i == w);
      imem_rdata = (i == w) ? word : $urandom;
      step();
    end
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i <= d; i++) begin
      chk("exec_req", 32'(req[0]), 32'd0);
      chk("exec_valid", 32'(valid[0]), 32'd1);
      // Stray memory strobes during EXEC must be ignored.
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      if (i == d) begin
        exec_done = 1'b1;
        branch = b;
        zero = z;
        jump = j;
      end else begin
        exec_done = 1'b0;
        branch = 1'($urandom);
        zero = 1'($urandom);
        jump = 1'($urandom);
      end
      step();
    end
    exec_done = 1'b0;
    imem_ready = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    jump = 1'b0;
    for (int k = 0; k < 2; k++) m_pc[k] = ref_next(m_pc[k], word, b, z, j);
    m_count = m_count + 32'd1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [31:0] W_ADD   = 32'h012A_4020;  // add $t0,$t1,$t2
  localparam logic [31:0] W_LW    = 32'h8D09_0004;  // lw  $t1,4($t0)
  localparam logic [31:0] W_SW    = 32'hAD09_0008;  // sw  $t1,8($t0)
  localparam logic [31:0] W_BEQ_M4 = 32'h1109_FFFC; // beq imm=-4
  localparam logic [31:0] W_BEQ_M2 = 32'h1109_FFFE; // beq imm=-2
  localparam logic [31:0] W_J_4   = 32'h0800_0004;  // j index 4
  localparam logic [31:0] W_J_100 = 32'h0800_0100;  // j index 0x100

  initial begin
    logic [31:0] rw;
    logic        rb, rz, rj;

    do_reset();
    chk("first_fetch_req", 32'(req[0]), 32'd1);
    chk("first_fetch_addr", addr[0], 32'h0);

    // Zero-wait straight-line code.
    run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(W_LW,  0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(W_SW,  0, 0, 1'b0, 1'b0, 1'b0);
    chk("count_after_3", count[0], 32'd3);
    chk("addr_after_3", addr[0], 32'hC);

    // Five wait states: request held six cycles with a stable address.
    run_instr(W_ADD, 5, 1, 1'b0, 1'b0, 1'b0);
    chk("wait_no_err", 32'(err[0]), 32'd0);
    chk("addr_0x10", addr[0], 32'h10);

    // BEQ at 0x10 with imm=-4: taken -> 0x4, not taken -> 0x14.
    run_instr(W_BEQ_M4, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("beq_taken", addr[0], 32'h4);
    run_instr(W_J_4, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("jump_back_0x10", addr[0], 32'h10);
    run_instr(W_BEQ_M4, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("beq_not_taken", addr[0], 32'h14);

    // Jump from 0x8000_0040 (high instance), alone and with branch&zero set.
    do_reset();
    run_instr(W_J_100, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("jump_hi", addr[1], 32'h8000_0400);
    do_reset();
    run_instr(W_J_100, 0, 2, 1'b1, 1'b1, 1'b1);
    chk("jump_priority_hi", addr[1], 32'h8000_0400);

    // Branch backwards past zero to exercise 32-bit wrap of pc_plus4.
    do_reset();
    run_instr(W_BEQ_M2, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("wrap_pc", addr[0], 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4[0], 32'h0);
    run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("wrap_next", addr[0], 32'h0);

    // Ready arriving in the last allowed cycle is still accepted.
    run_instr(W_LW, TIMEOUT - 1, 0, 1'b0, 1'b0, 1'b0);
    chk("late_ready_no_err", 32'(err[0]), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      rw = $urandom;
      rj = ($urandom_range(0, 3) == 0);
      rb = 1'($urandom);
      rz = 1'($urandom);
      run_instr(rw, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), rb, rz, rj);
    end
    chk("random_count", count[0], m_count);

    // Reset asserted while an instruction is executing.
    sb_q.push_back('{m_pc[0], m_pc[1], W_SW, m_count});
    imem_ready = 1'b1;
    imem_rdata = W_SW;
    step();
    imem_ready = 1'b0;
    chk("pre_rst_exec_valid", 32'(valid[0]), 32'd1);
    do_reset();
    chk("post_rst_addr", addr[0], RESET_LO);

    // Timeout: memory never answers.
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      chk("to_req", 32'(req[0]), 32'd1);
      chk("to_err_clear", 32'(err[0]), 32'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        chk("to_err_set", 32'(err[k]), 32'd1);
        chk("to_req_low", 32'(req[k]), 32'd0);
        chk("to_valid_low", 32'(valid[k]), 32'd0);
      end
      imem_ready = 1'b1;
      exec_done = 1'b1;
      imem_rdata = $urandom;
      step();
    end
    imem_ready = 1'b0;
    exec_done = 1'b0;
    do_reset();
    chk("to_cleared_err", 32'(err[0]), 32'd0);
    chk("to_restart_req", 32'(req[0]), 32'd1);
    chk("to_restart_addr", addr[0], RESET_LO);
    run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
    step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
